pwm_core: RTL and testbench
===========================

PWM_CORE -- requirements
Module: pwm_core

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of period/duty/divisor/counter datapath.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ctrl  input  8  control: [0] enable, [1] output enable, [2] polarity (1 = active-low), [3] one-shot, [4] irq enable, [6] counter hold, [5],[7] ignored.
REQ-005 SHALL have port divisor  input  CNT_W  prescale value; tick every divisor+1 clk.
REQ-006 SHALL have port period  input  CNT_W  PWM period; period+1 ticks per PWM cycle.
REQ-007 SHALL have port duty_cycle  input  CNT_W  ticks per cycle output is active.
REQ-008 SHALL have port irq_ack  input  1  single-cycle pulse clearing irq.
REQ-009 SHALL have port pwm_out  output  1  registered PWM waveform.
REQ-010 SHALL have port irq  output  1  sticky period-end interrupt, level.
REQ-011 SHALL have port running  output  1  high in state RUN.
REQ-012 SHALL have port cnt_value  output  CNT_W  current period counter, for readback.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL transition IDLE->RUN on cycle with ctrl[0]=1; same edge loads shadow divisor/period/duty from inputs, clears prescaler and cnt.
REQ-015 SHALL transition RUN->DONE at period end when shadow-sampled ctrl[3]=1; else stay RUN.
REQ-016 SHALL transition any state->IDLE on cycle with ctrl[0]=0; prescaler and cnt cleared same edge.
REQ-017 SHALL stay in DONE until ctrl[0]=0 (re-arm requires enable 1->0->1).
REQ-018 Prescaler SHALL count 0..div_sh in RUN; tick asserted in cycle where prescaler==div_sh, prescaler wraps to 0; divisor=0 -> tick every clk.
REQ-019 cnt SHALL advance only on tick: cnt==per_sh -> cnt<=0 and period-end event; else cnt+1; arithmetic modulo 2^CNT_W never reached since wrap at per_sh.
REQ-020 At period end SHALL reload shadows from inputs, so CSR writes take effect only at next cycle boundary (glitch-free).
REQ-021 Raw active SHALL be (cnt < duty_sh), unsigned compare; duty=0 -> never active; duty>period -> always active (100%).
REQ-022 pwm_out SHALL be registered: RUN and ctrl[1]=1 -> raw XOR ctrl[2]; otherwise ctrl[2] (inactive level); one clk latency from cnt.
REQ-023 In DONE pwm_out SHALL hold inactive level ctrl[2].
REQ-024 While ctrl[6]=1 in RUN, prescaler and cnt SHALL hold 0, shadows reload every clk, no period-end events; counting resumes cycle after release.
REQ-025 irq SHALL set on period-end event when ctrl[4]=1; clear on irq_ack=1; simultaneous set and ack -> irq stays 1.
REQ-026 irq SHALL remain set across RUN->IDLE/DONE transitions until acked.
REQ-027 cnt_value SHALL equal cnt register; running SHALL be registered state decode.

Reset
REQ-028 On reset SHALL force state IDLE, prescaler 0, cnt 0, shadows 0, pwm_out 0, irq 0, running 0, cnt_value 0.
REQ-029 Reset asserted mid-RUN SHALL abort immediately; after release block remains IDLE until ctrl[0] seen high.

Verification
REQ-030 divisor=0, period=9, duty=3, ctrl=0x03 -> pwm_out high 3 clk, low 7 clk, repeating, first high 1 clk after enable edge.
REQ-031 divisor=1, period=3, duty=2, ctrl=0x07 -> pwm_out low 4 clk, high 4 clk per 8-clk period; running=1.
REQ-032 Running period=9 duty=3, change duty to 8 mid-cycle -> current cycle keeps 3-tick active, next cycle 8 ticks.
REQ-033 duty=0 -> pwm_out constantly 0; duty=12 period=9 -> constantly 1 (ctrl[2]=0).
REQ-034 ctrl=0x1B, period=4, divisor=0 -> one 5-clk cycle, irq=1, state DONE, pwm_out=0; irq_ack with coincident period-end keeps irq=1; ack alone clears.
REQ-035 Reset pulse mid-RUN -> all outputs 0 next sample; re-enable restarts at cnt=0.

Source files
------------

// File: rtl/pwm_core.sv
// PWM generator with prescaler, glitch-free shadowed period/duty, one-shot mode
// and a sticky period-end interrupt.
module pwm_core #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       ctrl,
  input  logic [CNT_W-1:0] divisor,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_cycle,
  input  logic             irq_ack,
  output logic             pwm_out,
  output logic             irq,
  output logic             running,
  output logic [CNT_W-1:0] cnt_value
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] presc, cnt;
  logic [CNT_W-1:0] div_sh, per_sh, duty_sh;
  logic             oneshot_sh;

  logic enable, out_en, polarity, irq_en, hold;
  logic tick, period_end, load_sh, clear_cnt;
  logic pwm_next;
  logic unused_ctrl;

  assign enable      = ctrl[0];
  assign out_en      = ctrl[1];
  assign polarity    = ctrl[2];
  assign irq_en      = ctrl[4];
  assign hold        = ctrl[6];
  assign unused_ctrl = ^{ctrl[7], ctrl[5]};

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    tick       = 1'b0;
    period_end = 1'b0;
    load_sh    = 1'b0;
    clear_cnt  = 1'b0;
    case (state)
      IDLE: begin
        clear_cnt = 1'b1;
        if (enable) begin
          state_next = RUN;
          load_sh    = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = IDLE;
          clear_cnt  = 1'b1;
        end else if (hold) begin
          // Hold keeps the counters parked at 0 and tracks the CSR inputs live.
          clear_cnt = 1'b1;
          load_sh   = 1'b1;
        end else begin
          tick = (presc == div_sh);
          if (tick && (cnt == per_sh)) begin
            period_end = 1'b1;
            load_sh    = 1'b1;
            if (oneshot_sh) state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!enable) begin
          state_next = IDLE;
          clear_cnt  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        clear_cnt  = 1'b1;
      end
    endcase
  end

  // Output is the inactive level except while actively generating.
  always_comb begin
    pwm_next = polarity;
    if ((state == RUN) && out_en) pwm_next = (cnt < duty_sh) ^ polarity;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      cnt   <= '0;
    end else if (clear_cnt) begin
      presc <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + CNT_W'(1);
      if (tick) cnt <= period_end ? '0 : cnt + CNT_W'(1);
    end
  end

  // Shadows are few flops and software can read their effect, so they get a defined reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_sh     <= '0;
      per_sh     <= '0;
      duty_sh    <= '0;
      oneshot_sh <= 1'b0;
    end else if (load_sh) begin
      div_sh     <= divisor;
      per_sh     <= period;
      duty_sh    <= duty_cycle;
      oneshot_sh <= ctrl[3];
    end
  end

  // A coincident period-end wins over the acknowledge so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out <= 1'b0;
      irq     <= 1'b0;
    end else begin
      pwm_out <= pwm_next;
      if (period_end && irq_en) irq <= 1'b1;
      else if (irq_ack)         irq <= 1'b0;
    end
  end

  assign cnt_value = cnt;

endmodule

// File: tb/tb_pwm_core.sv
// Directed bench for pwm_core: expected PWM waveforms are queued from the
// specified timing formulas and popped as the DUT produces each sample.
module tb_pwm_core;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       ctrl;
  logic [CNT_W-1:0] divisor, period, duty_cycle;
  logic             irq_ack;
  logic             pwm_out, irq, running;
  logic [CNT_W-1:0] cnt_value;

  typedef struct {
    string tag;
    logic  val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pwm_core #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl       (ctrl),
    .divisor    (divisor),
    .period     (period),
    .duty_cycle (duty_cycle),
    .irq_ack    (irq_ack),
    .pwm_out    (pwm_out),
    .irq        (irq),
    .running    (running),
    .cnt_value  (cnt_value)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; samples are taken 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check(e.tag, {31'b0, pwm_out}, {31'b0, e.val});
    end
  endtask

  task automatic configure(input logic [7:0] c, input int dv, input int pr, input int dt);
    ctrl       = 8'h00;
    step();
    divisor    = CNT_W'(dv);
    period     = CNT_W'(pr);
    duty_cycle = CNT_W'(dt);
    ctrl       = c;
    step();
  endtask

  initial begin
    reset      = 1'b1;
    ctrl       = 8'h00;
    divisor    = '0;
    period     = '0;
    duty_cycle = '0;
    irq_ack    = 1'b0;
    #12;
    check("rst_pwm", {31'b0, pwm_out}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_running", {31'b0, running}, 32'd0);
    check("rst_cnt", {16'b0, cnt_value}, 32'd0);
    reset = 1'b0;
    step(); step(); step();
    check("idle_no_enable", {31'b0, running}, 32'd0);

    // divisor 0, period 9, duty 3: 3 high / 7 low, first high one clk after enable edge.
    divisor = 16'd0; period = 16'd9; duty_cycle = 16'd3; ctrl = 8'h03;
    step();
    check("r030_running", {31'b0, running}, 32'd1);
    check("r030_pwm_e0", {31'b0, pwm_out}, 32'd0);
    for (int k = 1; k <= 22; k++) push($sformatf("r030_k%0d", k), ((k - 1) % 10) < 3);
    drain();
    check("r030_cnt", {16'b0, cnt_value}, 32'd2);

    // Duty change mid-cycle takes effect only at the next period boundary.
    duty_cycle = 16'd8;
    for (int k = 23; k <= 42; k++)
      push($sformatf("r032_k%0d", k), ((k - 1) % 10) < (((k - 1) >= 30) ? 8 : 3));
    drain();

    // duty 0 never active, duty above period always active.
    configure(8'h03, 0, 9, 0);
    for (int k = 0; k < 12; k++) push($sformatf("r033_d0_%0d", k), 1'b0);
    drain();
    configure(8'h03, 0, 9, 12);
    for (int k = 0; k < 12; k++) push($sformatf("r033_d12_%0d", k), 1'b1);
    drain();

    // divisor 1, active-low: 4 low then 4 high per 8 clk period.
    configure(8'h07, 1, 3, 2);
    for (int k = 1; k <= 16; k++)
      push($sformatf("r031_k%0d", k), !((((k - 1) / 2) % 4) < 2));
    drain();
    check("r031_running", {31'b0, running}, 32'd1);

    // One-shot with irq: a single 5-clk cycle then DONE.
    configure(8'h1B, 0, 4, 2);
    for (int k = 1; k <= 6; k++) push($sformatf("r034_k%0d", k), (k - 1) < 2);
    drain();
    check("r034_irq_set", {31'b0, irq}, 32'd1);
    check("r034_done_running", {31'b0, running}, 32'd0);
    check("r034_done_cnt", {16'b0, cnt_value}, 32'd0);
    for (int k = 0; k < 8; k++) push($sformatf("r034_done_pwm_%0d", k), 1'b0);
    drain();
    check("r034_stay_done", {31'b0, running}, 32'd0);
    check("r034_irq_sticky", {31'b0, irq}, 32'd1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("r034_ack_clears", {31'b0, irq}, 32'd0);

    // Continuous mode: ack coincident with period end leaves irq set.
    configure(8'h13, 0, 4, 2);
    step(); step(); step(); step();
    check("r025_pre_irq", {31'b0, irq}, 32'd0);
    check("r025_pre_cnt", {16'b0, cnt_value}, 32'd4);
    irq_ack = 1'b1;
    step();
    check("r025_coincident", {31'b0, irq}, 32'd1);
    step();
    irq_ack = 1'b0;
    check("r025_ack_alone", {31'b0, irq}, 32'd0);

    // Counter hold parks counters at 0, counting resumes after release.
    configure(8'h03, 0, 9, 3);
    step(); step(); step();
    check("r024_pre_cnt", {16'b0, cnt_value}, 32'd3);
    ctrl = 8'h43;
    step(); step(); step();
    check("r024_hold_cnt", {16'b0, cnt_value}, 32'd0);
    check("r024_hold_running", {31'b0, running}, 32'd1);
    ctrl = 8'h03;
    step();
    check("r024_resume_cnt", {16'b0, cnt_value}, 32'd1);
    check("r024_resume_pwm", {31'b0, pwm_out}, 32'd1);

    // Asynchronous reset mid-run aborts at once; re-enable restarts at cnt 0.
    #2 reset = 1'b1;
    #1;
    check("r035_pwm", {31'b0, pwm_out}, 32'd0);
    check("r035_irq", {31'b0, irq}, 32'd0);
    check("r035_running", {31'b0, running}, 32'd0);
    check("r035_cnt", {16'b0, cnt_value}, 32'd0);
    reset = 1'b0;
    step();
    check("r035_restart_running", {31'b0, running}, 32'd1);
    check("r035_restart_cnt", {16'b0, cnt_value}, 32'd0);
    step();
    check("r035_cnt1", {16'b0, cnt_value}, 32'd1);
    check("r035_pwm1", {31'b0, pwm_out}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
